reset_sequencer: RTL and testbench

Parametrised reset controller that replaces the fixed 16-cycle power-on reset. It sits at the top of the clock-master design, directly behind the clock source. It synchronises an asynchronous active-low board reset, holds all resets for a programmable time, and waits for a filtered clock-lock indication. It then releases N downstream reset domains one at a time, re-running the sequence on lock loss or software request.

---
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset controller with lock qualification
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCK_FILTER    = 4,
  parameter int STAGGER_CYCLES = 8,
  parameter int N_OUT          = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  input  logic             i_soft_rst,
  output logic [N_OUT-1:0] o_rst,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_lock_lost
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_int;
  logic                   lock_s;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [SW-1:0]     stag_q, stag_d;
  logic [N_OUT-1:0]  rst_q, rst_d;
  logic              lost_q, lost_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Lock synchroniser runs during the internal reset tail so lock is already qualified at release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign rst_int = rst_sync[SYNC_STAGES-1];
  assign lock_s  = lock_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      filt_q  <= '0;
      stag_q  <= '0;
      rst_q   <= '1;
      lost_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      filt_q  <= filt_d;
      stag_q  <= stag_d;
      rst_q   <= rst_d;
      lost_q  <= lost_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    filt_d  = filt_q;
    stag_d  = stag_q;
    rst_d   = rst_q;
    lost_d  = lost_q;

    case (state_q)
      ST_ASSERT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = ST_RELEASE;
          filt_d  = '0;
          stag_d  = '0;
          rst_d   = rst_q << 1;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      // Shifting left clears the lowest still-asserted bit, so release order is fixed by construction.
      ST_RELEASE: begin
        if (rst_q == '0) begin
          state_d = ST_RUN;
        end else if (stag_q == STAG_LAST) begin
          stag_d = '0;
          rst_d  = rst_q << 1;
        end else begin
          stag_d = stag_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    if (!lock_s && (state_q == ST_RELEASE || state_q == ST_RUN)) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      filt_d  = '0;
      stag_d  = '0;
      rst_d   = '1;
      lost_d  = 1'b1;
    end

    if (i_soft_rst) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      filt_d  = '0;
      stag_d  = '0;
      rst_d   = '1;
      lost_d  = 1'b0;
    end

    if (!rst_int) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      filt_d  = '0;
      stag_d  = '0;
      rst_d   = '1;
      lost_d  = 1'b0;
    end

    ready_d = (state_d == ST_RUN);
    busy_d  = !ready_d;
  end

  assign o_rst       = rst_q;
  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_lock_lost = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - bench for reset_sequencer, default and minimal configurations
module tb_reset_sequencer;

  localparam int SYNC = 2;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_locked;
  logic       i_soft_rst;
  logic [3:0] o_rst0;
  logic       ready0, busy0, lost0;
  logic [0:0] o_rst1;
  logic       ready1, busy1, lost1;

  int checks   = 0;
  int failures = 0;

  int rise = 0;
  int e    = 0;
  bit lk[$];
  int m_ts[2];
  int m_tq[2];
  int m_run[2];
  bit m_lost[2];

  int lock_left = 0;
  int soft_left = 0;
  int rst_left  = 0;

  reset_sequencer dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_locked(i_locked), .i_soft_rst(i_soft_rst),
    .o_rst(o_rst0), .o_ready(ready0), .o_busy(busy0), .o_lock_lost(lost0)
  );

  reset_sequencer #(
    .HOLD_CYCLES(1), .LOCK_FILTER(1), .STAGGER_CYCLES(8), .N_OUT(1), .SYNC_STAGES(SYNC)
  ) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_locked(i_locked), .i_soft_rst(i_soft_rst),
    .o_rst(o_rst1), .o_ready(ready1), .o_busy(busy1), .o_lock_lost(lost1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int p_hold(input int i); return (i == 0) ? 16 : 1; endfunction
  function automatic int p_filt(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int p_stag(input int i); return 8; endfunction
  function automatic int p_n(input int i);    return (i == 0) ? 4 : 1; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a sequence starts at m_ts, qualifies at m_tq, releases follow arithmetically.
  task automatic model_restart(input int i, input int at);
    m_ts[i]  = at;
    m_tq[i]  = -1;
    m_run[i] = 0;
  endtask

  task automatic model_step();
    bit ls;
    bit released;
    if (!i_rst_n) begin
      rise = 0;
      e    = 0;
      lk.delete();
      for (int i = 0; i < 2; i++) begin
        model_restart(i, 1);
        m_lost[i] = 1'b0;
      end
    end else begin
      rise++;
      lk.push_back(i_locked);
      e = rise - SYNC;
      if (e >= 1) begin
        ls = lk[e-1];
        for (int i = 0; i < 2; i++) begin
          released = (m_tq[i] >= 1);
          if (!released && e >= m_ts[i] + p_hold(i)) begin
            if (ls) begin
              m_run[i]++;
              if (m_run[i] == p_filt(i)) m_tq[i] = e;
            end else begin
              m_run[i] = 0;
            end
          end
          if (released && !ls) begin
            m_lost[i] = 1'b1;
            model_restart(i, e + 1);
          end
          if (i_soft_rst) begin
            m_lost[i] = 1'b0;
            model_restart(i, e + 1);
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_rst(input int i);
    int r;
    logic [31:0] mask;
    mask = (32'd1 << p_n(i)) - 32'd1;
    if (m_tq[i] < 1) return mask;
    r = 1 + (e - m_tq[i]) / p_stag(i);
    if (r > p_n(i)) r = p_n(i);
    return mask & ~((32'd1 << r) - 32'd1);
  endfunction

  function automatic logic exp_ready(input int i);
    return (m_tq[i] >= 1) && (e >= m_tq[i] + (p_n(i) - 1) * p_stag(i) + 1);
  endfunction

  always @(posedge i_clk) begin
    model_step();
    #1;
    chk("dut0_rst",   {28'd0, o_rst0}, exp_rst(0));
    chk("dut0_ready", 32'(ready0), 32'(exp_ready(0)));
    chk("dut0_busy",  32'(busy0),  32'(!exp_ready(0)));
    chk("dut0_lost",  32'(lost0),  32'(m_lost[0]));
    chk("dut1_rst",   {31'd0, o_rst1}, exp_rst(1));
    chk("dut1_ready", 32'(ready1), 32'(exp_ready(1)));
    chk("dut1_busy",  32'(busy1),  32'(!exp_ready(1)));
    chk("dut1_lost",  32'(lost1),  32'(m_lost[1]));
  end

  task automatic wait_rst0(input logic [3:0] val, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge i_clk); #1;
      if (o_rst0 == val) hit = 1'b1;
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic wait_ready0(input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge i_clk); #1;
      if (ready0) hit = 1'b1;
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic lock_blip();
    @(negedge i_clk); i_locked = 1'b0;
    @(negedge i_clk); i_locked = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n    = 1'b0;
    i_locked   = 1'b1;
    i_soft_rst = 1'b0;
    repeat (3) @(posedge i_clk); #1;
    chk("por_rst0",   {28'd0, o_rst0}, 32'hF);
    chk("por_ready0", 32'(ready0), 32'd0);
    chk("por_busy0",  32'(busy0), 32'd1);
    chk("por_lost0",  32'(lost0), 32'd0);
    chk("por_rst1",   {31'd0, o_rst1}, 32'h1);

    // Power-up timeline from reset release
    @(negedge i_clk); i_rst_n = 1'b1;
    repeat (SYNC + 1) @(posedge i_clk); #1;
    chk("n1_e1_rst", {31'd0, o_rst1}, 32'h1);
    @(posedge i_clk); #1;
    chk("n1_e2_rst",   {31'd0, o_rst1}, 32'h0);
    chk("n1_e2_ready", 32'(ready1), 32'd0);
    @(posedge i_clk); #1;
    chk("n1_e3_ready", 32'(ready1), 32'd1);
    repeat (16) @(posedge i_clk); #1;
    chk("e19_rst", {28'd0, o_rst0}, 32'hF);
    @(posedge i_clk); #1;
    chk("e20_rst", {28'd0, o_rst0}, 32'hE);
    chk("model_e20_rst", exp_rst(0), 32'hE);
    repeat (8) @(posedge i_clk); #1;
    chk("e28_rst", {28'd0, o_rst0}, 32'hC);
    repeat (8) @(posedge i_clk); #1;
    chk("e36_rst", {28'd0, o_rst0}, 32'h8);
    repeat (8) @(posedge i_clk); #1;
    chk("e44_rst",   {28'd0, o_rst0}, 32'h0);
    chk("e44_ready", 32'(ready0), 32'd0);
    @(posedge i_clk); #1;
    chk("e45_ready", 32'(ready0), 32'd1);
    chk("e45_busy",  32'(busy0), 32'd0);
    chk("e45_lost",  32'(lost0), 32'd0);
    chk("model_e45_ready", 32'(exp_ready(0)), 32'd1);

    // Lock loss in RUN
    lock_blip();
    chk("ll_rst",   {28'd0, o_rst0}, 32'hF);
    chk("ll_lost",  32'(lost0), 32'd1);
    chk("ll_ready", 32'(ready0), 32'd0);
    repeat (50) @(posedge i_clk); #1;
    chk("ll_rerun_ready", 32'(ready0), 32'd1);
    chk("ll_rerun_lost",  32'(lost0), 32'd1);

    // Soft reset held for five cycles mid-RELEASE
    @(negedge i_clk); i_soft_rst = 1'b1;
    @(negedge i_clk); i_soft_rst = 1'b0;
    wait_rst0(4'hC, "sr_reach_1100");
    @(negedge i_clk); i_soft_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("sr_rst",  {28'd0, o_rst0}, 32'hF);
    chk("sr_lost", 32'(lost0), 32'd0);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk); i_soft_rst = 1'b0;
    repeat (19) @(posedge i_clk); #1;
    chk("sr_rst_19", {28'd0, o_rst0}, 32'hF);
    @(posedge i_clk); #1;
    chk("sr_rst_20", {28'd0, o_rst0}, 32'hE);

    // Lock flickering 3 high / 1 low must never qualify
    @(negedge i_clk); i_soft_rst = 1'b1;
    @(negedge i_clk); i_soft_rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge i_clk);
      i_locked = ((n % 4) != 3);
      @(posedge i_clk); #1;
      chk("flk_rst",  {28'd0, o_rst0}, 32'hF);
      chk("flk_busy", 32'(busy0), 32'd1);
    end
    @(negedge i_clk); i_locked = 1'b1;
    repeat (5) @(posedge i_clk); #1;
    chk("flk_hold_rst", {28'd0, o_rst0}, 32'hF);
    @(posedge i_clk); #1;
    chk("flk_rel_rst", {28'd0, o_rst0}, 32'hE);

    // Soft reset coinciding with lock loss in RUN
    wait_ready0("co_reach_run1");
    lock_blip();
    wait_ready0("co_reach_run2");
    chk("co_pre_lost", 32'(lost0), 32'd1);
    @(negedge i_clk); i_locked = 1'b0;
    @(negedge i_clk); i_locked = 1'b1;
    @(negedge i_clk); i_soft_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("co_lost",  32'(lost0), 32'd0);
    chk("co_rst",   {28'd0, o_rst0}, 32'hF);
    chk("co_ready", 32'(ready0), 32'd0);
    @(negedge i_clk); i_soft_rst = 1'b0;

    // Asynchronous board reset mid-RELEASE
    wait_rst0(4'hC, "ar_reach_1100");
    @(negedge i_clk); #2; i_rst_n = 1'b0;
    #1;
    chk("ar_rst0",   {28'd0, o_rst0}, 32'hF);
    chk("ar_ready0", 32'(ready0), 32'd0);
    chk("ar_busy0",  32'(busy0), 32'd1);
    chk("ar_rst1",   {31'd0, o_rst1}, 32'h1);
    chk("ar_ready1", 32'(ready1), 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;

    // Randomised stretch checked cycle-by-cycle against the model
    for (int n = 0; n < 8000; n++) begin
      @(negedge i_clk);
      if (lock_left == 0) begin
        if ($urandom_range(0, 99) < 75) begin
          i_locked  = 1'b1;
          lock_left = $urandom_range(10, 120);
        end else begin
          i_locked  = 1'b0;
          lock_left = $urandom_range(1, 6);
        end
      end
      lock_left--;
      if (soft_left > 0) soft_left--;
      else if ($urandom_range(0, 299) == 0) soft_left = $urandom_range(1, 6);
      i_soft_rst = (soft_left > 0);
      if (rst_left > 0) begin
        rst_left--;
        i_rst_n = (rst_left == 0);
      end else if ($urandom_range(0, 2999) == 0) begin
        rst_left = $urandom_range(1, 3);
        i_rst_n  = 1'b0;
      end
    end
    @(posedge i_clk); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
